// File: rtl/io_port_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : io_port_controller_pkg
// Purpose  : Shared types and constants for the CPU I/O port controller.
// Revision : 1.0 - initial release
// ============================================================================
package io_port_controller_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic IO_DIR_IN  = 1'b0;
    localparam logic IO_DIR_OUT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_IN_WAIT  = 2'd1,
        ST_OUT_WAIT = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

endpackage : io_port_controller_pkg
`default_nettype wire

// File: rtl/io_port_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : io_port_controller_if
// Purpose  : CPU request/response and device valid/ready signals of the port.
// Revision : 1.0 - initial release
// ============================================================================
interface io_port_controller_if
    import io_port_controller_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = 4
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic             io_req;
    logic             io_wr;
    logic [WIDTH-1:0] io_wdata;
    logic [WIDTH-1:0] io_rdata;
    logic             io_done;
    logic             io_err;
    logic             busy;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [CW-1:0]    fifo_count;

    modport master (
        output io_req, io_wr, io_wdata, in_valid, in_data, out_ready,
        input  io_rdata, io_done, io_err, busy, in_ready, out_valid, out_data, fifo_count
    );

    modport slave (
        input  io_req, io_wr, io_wdata, in_valid, in_data, out_ready,
        output io_rdata, io_done, io_err, busy, in_ready, out_valid, out_data, fifo_count
    );

endinterface : io_port_controller_if
`default_nettype wire

// File: rtl/io_port_controller_fifo.sv
`default_nettype none
// ============================================================================
// Module   : io_fifo
// Purpose  : Synchronous FIFO; status derives only from the registered count.
// Revision : 1.0 - initial release
// ============================================================================
module io_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  wire logic                       clk,
    input  wire logic                       clr,
    input  wire logic                       push,
    input  wire logic                       pop,
    input  wire logic [WIDTH-1:0]           din,
    output logic      [WIDTH-1:0]           dout,
    output logic                            full,
    output logic                            empty,
    output logic      [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    // Gating by registered status means a full FIFO refuses a push even while popping.
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rptr_q];
    assign count   = count_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din;
    end

endmodule : io_fifo
`default_nettype wire

// File: rtl/io_port_controller.sv
`default_nettype none
// ============================================================================
// Module   : io_port_controller
// Purpose  : Sequences CPU IN/OUT requests onto device handshakes with timeout.
// Revision : 1.0 - initial release
// ============================================================================
module io_port_controller
    import io_port_controller_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 16
) (
    input wire logic             clk,
    input wire logic             clr,
    io_port_controller_if.slave  bus
);
    localparam bit               TO_EN   = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             in_hit;
    logic             out_hit;
    logic             timeout_hit;

    assign in_hit      = ~fifo_empty;
    assign out_hit     = out_valid_q & bus.out_ready;
    assign timeout_hit = TO_EN && (cnt_q == TO_LAST);
    assign fifo_pop    = (state_q == ST_IN_WAIT) & ~fifo_empty;

    io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .clr   (clr),
        .push  (bus.in_valid),
        .pop   (fifo_pop),
        .din   (bus.in_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (bus.fifo_count)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Completion is tested before timeout so a last-cycle handshake is not an error.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (bus.io_req) state_d = (bus.io_wr == IO_DIR_IN) ? ST_IN_WAIT : ST_OUT_WAIT;
            ST_IN_WAIT:  if (in_hit || timeout_hit) state_d = ST_DONE;
            ST_OUT_WAIT: if (out_hit || timeout_hit) state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.io_done = (state_q == ST_DONE);
        bus.busy    = (state_q != ST_IDLE);
    end

    always_comb begin
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (bus.io_req && bus.io_wr == IO_DIR_OUT) begin
                    out_data_d  = bus.io_wdata;
                    out_valid_d = 1'b1;
                end
            end
            ST_IN_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (in_hit) begin
                    rdata_d = fifo_dout;
                    err_d   = 1'b0;
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end
            ST_OUT_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (out_hit) begin
                    out_valid_d = 1'b0;
                    err_d       = 1'b0;
                end else if (timeout_hit) begin
                    out_valid_d = 1'b0;
                    err_d       = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready  = ~fifo_full;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.io_rdata  = rdata_q;
    assign bus.io_err    = err_q;

endmodule : io_port_controller
`default_nettype wire

// File: tb/tb_io_port_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_port_controller
// Purpose  : Scoreboard bench for io_port_controller with an 8-cycle timeout.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_port_controller;
    import io_port_controller_pkg::*;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 16;

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    io_port_controller_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    io_port_controller #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    typedef struct {
        logic        wr;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   cyc       = 0;
    int   issue_cyc = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Latency counts clock edges from the one that samples io_req to the one raising io_done.
    task automatic issue(input logic wr, input logic [31:0] wdata,
                         input logic [31:0] erd, input logic eerr, input int elat);
        exp_t e;
        e.wr = wr; e.rdata = erd; e.err = eerr; e.lat = elat;
        sb.push_back(e);
        bus.io_req   = 1'b1;
        bus.io_wr    = wr;
        bus.io_wdata = wdata;
        issue_cyc    = cyc;
        tick();
        bus.io_req   = 1'b0;
    endtask

    task automatic wait_done();
        exp_t e;
        bit   seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            tick();
            if (bus.io_done === 1'b1) seen = 1'b1;
        end
        check("done_seen", 64'(seen), 64'd1);
        if (seen) begin
            check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
            check("busy_in_done", 64'(bus.busy), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("latency", 64'(cyc - issue_cyc), 64'(e.lat));
                check("io_err", 64'(bus.io_err), 64'(e.err));
                if (!e.wr) check("io_rdata", 64'(bus.io_rdata), 64'(e.rdata));
            end
        end
    endtask

    task automatic finish_done();
        tick();
        check("done_one_cycle", 64'(bus.io_done), 64'd0);
        check("busy_after_done", 64'(bus.busy), 64'd0);
    endtask

    task automatic do_in(input logic [31:0] erd);
        issue(IO_DIR_IN, 32'h0, erd, 1'b0, 2);
        wait_done();
        finish_done();
    endtask

    task automatic push_word(input logic [31:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int vcnt;
        bus.io_req    = 1'b0;
        bus.io_wr     = IO_DIR_IN;
        bus.io_wdata  = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        repeat (3) tick();
        check("rst_fifo_count", 64'(bus.fifo_count), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_io_rdata", 64'(bus.io_rdata), 64'd0);
        check("rst_io_done", 64'(bus.io_done), 64'd0);
        check("rst_io_err", 64'(bus.io_err), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        clr = 1'b1;
        tick();

        // Two queued words read back in arrival order.
        push_word(32'hA5A5_0001);
        push_word(32'hA5A5_0002);
        check("t1_fifo_count", 64'(bus.fifo_count), 64'd2);
        do_in(32'hA5A5_0001);
        check("t1_fifo_after", 64'(bus.fifo_count), 64'd1);
        do_in(32'hA5A5_0002);

        // OUT held off by the device for five cycles.
        vcnt = 0;
        issue(IO_DIR_OUT, 32'h0000_00FF, 32'h0, 1'b0, 7);
        for (int i = 0; i < 5; i++) begin
            if (bus.out_valid === 1'b1) vcnt++;
            check("t2_out_data_hold", 64'(bus.out_data), 64'hFF);
            tick();
        end
        bus.out_ready = 1'b1;
        if (bus.out_valid === 1'b1) vcnt++;
        wait_done();
        bus.out_ready = 1'b0;
        check("t2_valid_cycles", 64'(vcnt), 64'd6);
        check("t2_out_valid_low", 64'(bus.out_valid), 64'd0);
        check("t2_out_data_after", 64'(bus.out_data), 64'hFF);
        check("t2_rdata_kept", 64'(bus.io_rdata), 64'hA5A5_0002);
        finish_done();
        check("t2_out_data_later", 64'(bus.out_data), 64'hFF);

        // IN on an empty FIFO times out.
        issue(IO_DIR_IN, 32'h0, 32'h0, 1'b1, 9);
        wait_done();
        finish_done();

        // Full FIFO rejects a fifth word until a pop frees a slot.
        for (int i = 1; i <= 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'h1111_0000 + 32'(i);
            tick();
        end
        bus.in_data = 32'h0000_DEAD;
        check("t4_full_count", 64'(bus.fifo_count), 64'd4);
        check("t4_in_ready_full", 64'(bus.in_ready), 64'd0);
        tick();
        check("t4_not_stored", 64'(bus.fifo_count), 64'd4);
        issue(IO_DIR_IN, 32'h0, 32'h1111_0001, 1'b0, 2);
        wait_done();
        check("t4_in_ready_freed", 64'(bus.in_ready), 64'd1);
        check("t4_count_after_pop", 64'(bus.fifo_count), 64'd3);
        finish_done();
        bus.in_valid = 1'b0;
        check("t4_dead_stored", 64'(bus.fifo_count), 64'd4);
        do_in(32'h1111_0002);
        do_in(32'h1111_0003);
        do_in(32'h1111_0004);
        do_in(32'h0000_DEAD);

        // Asynchronous reset in the middle of an OUT transfer.
        push_word(32'h2222_0001);
        push_word(32'h2222_0002);
        push_word(32'h2222_0003);
        issue(IO_DIR_OUT, 32'h0000_5555, 32'h0, 1'b0, 0);
        check("t5_out_valid_pre", 64'(bus.out_valid), 64'd1);
        tick();
        #2;
        clr = 1'b0;
        #1;
        sb.delete();
        check("t5_out_valid_rst", 64'(bus.out_valid), 64'd0);
        check("t5_fifo_count_rst", 64'(bus.fifo_count), 64'd0);
        check("t5_busy_rst", 64'(bus.busy), 64'd0);
        check("t5_done_rst", 64'(bus.io_done), 64'd0);
        check("t5_out_data_rst", 64'(bus.out_data), 64'd0);
        tick();
        tick();
        clr = 1'b1;
        tick();
        issue(IO_DIR_IN, 32'h0, 32'h0, 1'b1, 9);
        wait_done();
        finish_done();

        // Handshake on the last counted cycle beats the timeout.
        issue(IO_DIR_OUT, 32'h0000_0077, 32'h0, 1'b0, 9);
        repeat (7) tick();
        check("t6_valid_last", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b1;
        wait_done();
        bus.out_ready = 1'b0;
        check("t6_out_data", 64'(bus.out_data), 64'h77);
        finish_done();

        // Dead output device: error, valid dropped, data retained.
        issue(IO_DIR_OUT, 32'h0000_0099, 32'h0, 1'b1, 9);
        wait_done();
        check("t7_out_valid_low", 64'(bus.out_valid), 64'd0);
        check("t7_out_data_kept", 64'(bus.out_data), 64'h99);
        finish_done();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_io_port_controller
`default_nettype wire

// File: doc/io_port_controller.md
Name: io_port_controller

Overview:
Sequences CPU IN/OUT instructions onto the external I/O devices through valid/ready handshakes. Input side: a small FIFO captures device words independently of the CPU. An IN request pops one word. An OUT request presents one word to the output device and holds it until accepted. A timeout counter bounds every transfer, so a dead device raises an error instead of hanging the control unit.

Parameters:
WIDTH, 32, data width of bus and device words
DEPTH, 4, input FIFO entries (power of two, >= 2)
TIMEOUT, 256, max wait cycles per transfer; 0 disables timeout
CNT_W, 16, timeout counter width (must hold TIMEOUT)

Ports:
clk  input  1  system clock, rising edge
clr  input  1  asynchronous, active-low reset
io_req  input  1  CPU request strobe, sampled only in IDLE
io_wr  input  1  1 = OUT (write device), 0 = IN (read device)
io_wdata  input  WIDTH  OUT data from bus
io_rdata  output  WIDTH  IN data to bus, valid when io_done=1
io_done  output  1  one-cycle completion pulse
io_err  output  1  qualifies io_done: transfer timed out
busy  output  1  high in any state other than IDLE
in_valid  input  1  input device offers in_data
in_data  input  WIDTH  input device word
in_ready  output  1  FIFO can accept (= not full)
out_valid  output  1  out_data offered to output device
out_data  output  WIDTH  output word; holds last value after transfer
out_ready  input  1  output device accepts
fifo_count  output  log2(DEPTH)+1  words held in input FIFO

Behaviour:
- Reset (clr=0, asynchronous, any state):
  - state=IDLE, FIFO flushed (fifo_count=0, in_ready=1).
  - out_valid=0, out_data=0, io_rdata=0, io_done=0, io_err=0, timeout counter=0.
  - out_valid must drop without waiting for a clock edge.
- States: IDLE, IN_WAIT, OUT_WAIT, DONE. Encoding is local.
- IDLE:
  - io_req & !io_wr -> IN_WAIT.
  - io_req & io_wr -> OUT_WAIT; out_data<=io_wdata, out_valid<=1.
  - Counter cleared on entry to either wait state.
- IN_WAIT:
  - If FIFO not empty: pop head, io_rdata<=head, io_err<=0, -> DONE.
  - Best case: req at edge N, pop at N+1, io_done high during cycle after N+1 (2-cycle latency).
- OUT_WAIT:
  - On out_valid & out_ready: out_valid<=0, io_err<=0, -> DONE.
  - out_data stays stable while out_valid=1 and after completion.
- Timeout:
  - If TIMEOUT>0 and counter==TIMEOUT-1 with no completion that cycle: io_err<=1 and -> DONE.
  - IN timeout: io_rdata<=0.
  - OUT timeout: out_valid<=0, out_data retained.
  - Completion and timeout in the same cycle: completion wins, err=0.
- DONE: io_done=1 for exactly one cycle, then -> IDLE. io_req is ignored in DONE and in both wait states.
- io_rdata and io_err hold their value until the next completion.
- FIFO push and pop:
  - Push when in_valid & in_ready.
  - in_ready = !full, registered-count based, so no combinational path from pop.
  - Full FIFO: no push, even if a pop happens the same cycle.
  - Empty FIFO: a same-cycle push is not poppable until the next cycle; no bypass.
- Pointers wrap modulo DEPTH. fifo_count saturates at neither end, because overflow and underflow are impossible by construction.
- Input words arriving while no IN is pending are retained in order, up to DEPTH.

Decomposition:
- Shared package: state enumeration, IO_DIR_IN/IO_DIR_OUT constants, default WIDTH.
- Sub-module io_fifo (sync FIFO):
  - Parameters: WIDTH, DEPTH.
  - Ports: push, pop, din, dout, full, empty, count.
  - Same clk/clr convention.
- The FSM and timeout counter stay in io_port_controller.

Test Plan:
1. Reset, then in_valid=1 with 0xA5A5_0001, 0xA5A5_0002 -> fifo_count=2. An IN request returns io_rdata=0xA5A5_0001, io_done 2 cycles after io_req, io_err=0. A second IN returns 0xA5A5_0002.
2. OUT io_wdata=0x0000_00FF with out_ready held 0 for 5 cycles, then 1 -> out_valid high 6 cycles. out_data=0xFF throughout and after. io_done one cycle after the handshake, io_err=0.
3. TIMEOUT=8, IN on empty FIFO, no device data -> io_done with io_err=1 and io_rdata=0 after 8 wait cycles. busy low the following cycle.
4. Fill FIFO with 4 words; 5th word 0xDEAD held on in_valid -> in_ready=0 and not stored. An IN pop brings in_ready=1 next cycle. 0xDEAD is then stored as 4th entry, preserving order.
5. Assert clr=0 mid-OUT_WAIT (out_valid=1, 3 words queued) -> out_valid, fifo_count, busy, io_done all 0 immediately. After release, an IN times out (FIFO flushed).
6. out_ready rises on the exact cycle the counter reaches TIMEOUT-1 -> transfer completes with io_err=0.
